// File: rtl/gate_check_pkg.sv
// Shared constants for the gate bank checker: FSM states, output bit positions, golden table.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gate_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bit positions of each gate output inside the 7-bit observed/expected bus
    localparam int NAND_B = 6;
    localparam int NOT_B  = 5;
    localparam int AND_B  = 4;
    localparam int OR_B   = 3;
    localparam int NOR_B  = 2;
    localparam int XOR_B  = 1;
    localparam int XNOR_B = 0;

    // Golden responses, indexed by {a,b}
    localparam logic [6:0] GOLD_00 = 7'b1100101;
    localparam logic [6:0] GOLD_01 = 7'b1101010;
    localparam logic [6:0] GOLD_10 = 7'b1001010;
    localparam logic [6:0] GOLD_11 = 7'b0011001;

endpackage

// File: rtl/gate_golden_rom.sv
// Golden lookup: maps the 2-bit input vector {a,b} to the expected 7 gate outputs.
// Latency: purely combinational.
// Backpressure: none; always ready.
module gate_golden_rom
    import gate_check_pkg::*;
(
    input  logic [1:0] vec_i,
    output logic [6:0] expected_o
);

    // Table lookup
    always_comb begin
        expected_o = GOLD_00;
        case (vec_i)
            2'd0:    expected_o = GOLD_00;
            2'd1:    expected_o = GOLD_01;
            2'd2:    expected_o = GOLD_10;
            default: expected_o = GOLD_11;
        endcase
    end

endmodule

// File: rtl/gate_bank_checker.sv
// BIST driver/checker for a 2-input gate bank; optional first-failure capture under GATE_CHECK_FIRST_FAIL_EN.
// Latency: LOOPS*4*(SETTLE_CYCLES+2) cycles from first DRIVE to last CHECK, done pulse one cycle later.
// Backpressure: none; start is only sampled in IDLE and ignored while a run is in progress.
module gate_bank_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             nandab,
    input  logic             nota,
    input  logic             andab,
    input  logic             orab,
    input  logic             norab,
    input  logic             xorab,
    input  logic             xnorab,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [6:0]       fail_mask
`ifdef GATE_CHECK_FIRST_FAIL_EN
    ,
    output logic [1:0]       first_fail_vec,
    output logic [6:0]       first_fail_diff,
    output logic [0:0]       first_fail_valid
`endif
);

    // Counter widths: settle counts 0..SETTLE_CYCLES-1, loop counts 0..LOOPS-1
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [LW-1:0]    loop_q, loop_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             a_q, a_d, b_q, b_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [6:0]       mask_q, mask_d;
    logic [6:0]       expected;
    logic [6:0]       observed;
    logic [6:0]       diff;
`ifdef GATE_CHECK_FIRST_FAIL_EN
    logic [1:0]       ff_vec_q, ff_vec_d;
    logic [6:0]       ff_diff_q, ff_diff_d;
    logic             ff_vld_q, ff_vld_d;
`endif

    gate_golden_rom u_rom (
        .vec_i      (vec_q),
        .expected_o (expected)
    );

    assign observed = {nandab, nota, andab, orab, norab, xorab, xnorab};
    assign diff     = observed ^ expected;

    // State and datapath registers; synchronous reset aborts any run in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            loop_q    <= '0;
            settle_q  <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            mask_q    <= '0;
`ifdef GATE_CHECK_FIRST_FAIL_EN
            ff_vec_q  <= '0;
            ff_diff_q <= '0;
            ff_vld_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            loop_q    <= loop_d;
            settle_q  <= settle_d;
            a_q       <= a_d;
            b_q       <= b_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
`ifdef GATE_CHECK_FIRST_FAIL_EN
            ff_vec_q  <= ff_vec_d;
            ff_diff_q <= ff_diff_d;
            ff_vld_q  <= ff_vld_d;
`endif
        end
    end

    // Next-state: walk the four vectors LOOPS times, checking each after the settle window
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        loop_d   = loop_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        pass_d   = pass_q;
        err_d    = err_q;
        mask_d   = mask_q;
`ifdef GATE_CHECK_FIRST_FAIL_EN
        ff_vec_d  = ff_vec_q;
        ff_diff_d = ff_diff_q;
        ff_vld_d  = ff_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    err_d   = '0;
                    mask_d  = '0;
                    vec_d   = '0;
                    loop_d  = '0;
                    pass_d  = 1'b0;
`ifdef GATE_CHECK_FIRST_FAIL_EN
                    ff_vec_d  = '0;
                    ff_diff_d = '0;
                    ff_vld_d  = 1'b0;
`endif
                end
            end
            ST_DRIVE: begin
                a_d      = vec_q[1];
                b_d      = vec_q[0];
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_CHECK: begin
                mask_d = mask_q | diff;
                if ((diff != '0) && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
`ifdef GATE_CHECK_FIRST_FAIL_EN
                if ((diff != '0) && !ff_vld_q) begin
                    ff_vec_d  = vec_q;
                    ff_diff_d = diff;
                    ff_vld_d  = 1'b1;
                end
`endif
                if ((vec_q == 2'd3) && (loop_q == LW'(LOOPS - 1))) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        loop_d = loop_q + LW'(1);
                    end
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                // err_q already includes the final CHECK
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_mask = mask_q;
`ifdef GATE_CHECK_FIRST_FAIL_EN
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_diff  = ff_diff_q;
    assign first_fail_valid = ff_vld_q;
`endif

endmodule

// File: tb/tb_gate_bank_checker.sv
// Bench for gate_bank_checker: three instances (default, saturating 2-loop, fast settle) with faultable gate banks.
// Latency: expected results queued at stimulus, compared when done pulses.
// Backpressure: n/a.
module tb_gate_bank_checker;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] a_v, b_v, busy_v, done_v, pass_v;
    logic [7:0] err0, err2;
    logic [1:0] err1;
    logic [6:0] mask0, mask1, mask2;
    logic [6:0] g0, g1, g2;
    logic [1:0] fault0, fault1, fault2;
    logic [31:0] err_a [3];
    logic [6:0]  mask_a [3];
    logic [1:0]  ab_tr [0:255];
`ifdef GATE_CHECK_FIRST_FAIL_EN
    logic [1:0] ffv0, ffv1, ffv2;
    logic [6:0] ffd0, ffd1, ffd2;
    logic [0:0] ffl0, ffl1, ffl2;
`endif

    typedef struct {
        int         cycles;
        int         err;
        logic [6:0] mask;
        logic       pass;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate bank with optional stuck faults: 1 = xorab stuck 0, 2 = andab stuck 1
    function automatic logic [6:0] gate_model(input logic ia, input logic ib, input logic [1:0] mode);
        logic [6:0] r;
        r = {~(ia & ib), ~ia, ia & ib, ia | ib, ~(ia | ib), ia ^ ib, ~(ia ^ ib)};
        if (mode == 2'd1) r[1] = 1'b0;
        if (mode == 2'd2) r[4] = 1'b1;
        return r;
    endfunction

    function automatic logic [6:0] gold(input logic [1:0] v);
        case (v)
            2'd0:    return 7'b1100101;
            2'd1:    return 7'b1101010;
            2'd2:    return 7'b1001010;
            default: return 7'b0011001;
        endcase
    endfunction

    assign g0 = gate_model(a_v[0], b_v[0], fault0);
    assign g1 = gate_model(a_v[1], b_v[1], fault1);
    assign g2 = gate_model(a_v[2], b_v[2], fault2);
    assign err_a[0]  = {24'd0, err0};
    assign err_a[1]  = {30'd0, err1};
    assign err_a[2]  = {24'd0, err2};
    assign mask_a[0] = mask0;
    assign mask_a[1] = mask1;
    assign mask_a[2] = mask2;

    gate_bank_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .nandab(g0[6]), .nota(g0[5]), .andab(g0[4]), .orab(g0[3]),
        .norab(g0[2]), .xorab(g0[1]), .xnorab(g0[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err0), .fail_mask(mask0)
`ifdef GATE_CHECK_FIRST_FAIL_EN
        , .first_fail_vec(ffv0), .first_fail_diff(ffd0), .first_fail_valid(ffl0)
`endif
    );

    gate_bank_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .nandab(g1[6]), .nota(g1[5]), .andab(g1[4]), .orab(g1[3]),
        .norab(g1[2]), .xorab(g1[1]), .xnorab(g1[0]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err1), .fail_mask(mask1)
`ifdef GATE_CHECK_FIRST_FAIL_EN
        , .first_fail_vec(ffv1), .first_fail_diff(ffd1), .first_fail_valid(ffl1)
`endif
    );

    gate_bank_checker #(.SETTLE_CYCLES(1), .LOOPS(1), .ERR_W(8)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .nandab(g2[6]), .nota(g2[5]), .andab(g2[4]), .orab(g2[3]),
        .norab(g2[2]), .xorab(g2[1]), .xnorab(g2[0]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err2), .fail_mask(mask2)
`ifdef GATE_CHECK_FIRST_FAIL_EN
        , .first_fail_vec(ffv2), .first_fail_diff(ffd2), .first_fail_valid(ffl2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, want);
        end
    endtask

    // One full run on instance d; expectations come from the bench's own model
    task automatic do_run(input int d, input int loops, input int settle, input int errw,
                          input logic [1:0] fault, input bit hold);
        exp_t       e;
        exp_t       r;
        logic [6:0] df;
        logic [1:0] vv;
        int         cyc;
        bit         got;
        int         extra;
        e.err  = 0;
        e.mask = '0;
        for (int l = 0; l < loops; l++) begin
            for (int v = 0; v < 4; v++) begin
                vv = 2'(v);
                df = gate_model(vv[1], vv[0], fault) ^ gold(vv);
                e.mask |= df;
                if (df != '0 && e.err < (1 << errw) - 1) e.err++;
            end
        end
        e.pass   = (e.err == 0);
        e.cycles = loops * 4 * (settle + 2) + 1;
        sb.push_back(e);

        @(negedge clk);
        start_v[d] = 1'b1;
        @(posedge clk);
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!hold) start_v[d] = 1'b0;
            ab_tr[cyc[7:0]] = {a_v[d], b_v[d]};
            if (cyc == 1) check("busy_first", 32'(busy_v[d]), 32'd1);
            if (done_v[d]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        r = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(r.cycles));
        check("err_cnt", err_a[d], 32'(r.err));
        check("fail_mask", 32'(mask_a[d]), 32'(r.mask));
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        check("pass", 32'(pass_v[d]), 32'(r.pass));
        check("done_pulse_len", 32'(done_v[d]), 32'd0);
        if (hold) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done_v[d] || busy_v[d]) extra++;
            end
            check("no_second_run", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int cyc;
        rst_n   = 1'b0;
        start_v = '0;
        fault0  = 2'd0;
        fault1  = 2'd0;
        fault2  = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_done", 32'(done_v[0]), 32'd0);
        check("rst_pass", 32'(pass_v[0]), 32'd0);
        check("rst_err", err_a[0], 32'd0);
        check("rst_mask", 32'(mask0), 32'd0);
        check("rst_ab", 32'({a_v[0], b_v[0]}), 32'd0);

        // Healthy bank
        do_run(0, 1, 2, 8, 2'd0, 1'b0);

        // xorab stuck at 0
        fault0 = 2'd1;
        do_run(0, 1, 2, 8, 2'd1, 1'b0);
`ifdef GATE_CHECK_FIRST_FAIL_EN
        check("ff_vec", 32'(ffv0), 32'd1);
        check("ff_diff", 32'(ffd0), 32'h02);
        check("ff_valid", 32'(ffl0), 32'd1);
`endif
        check("ab_hold_11", 32'({a_v[0], b_v[0]}), 32'd3);

        // andab stuck at 1, two loops, 2-bit saturating counter
        fault1 = 2'd2;
        do_run(1, 2, 2, 2, 2'd2, 1'b0);

        // start held high throughout the run and across DONE
        fault0 = 2'd0;
        do_run(0, 1, 2, 8, 2'd0, 1'b1);

        // Reset during SETTLE of vector 2, with a faulty bank so state is non-zero
        fault0 = 2'd1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        check("mid_rst_done", 32'(done_v[0]), 32'd0);
        check("mid_rst_err", err_a[0], 32'd0);
        check("mid_rst_mask", 32'(mask0), 32'd0);
        check("mid_rst_ab", 32'({a_v[0], b_v[0]}), 32'd0);
        fault0 = 2'd0;
        do_run(0, 1, 2, 8, 2'd0, 1'b0);

        // One-cycle settle window: done at 13, each vector held 3 cycles
        do_run(2, 1, 1, 8, 2'd0, 1'b0);
        check("ab_c1", 32'(ab_tr[1]), 32'd0);
        for (int c = 2; c <= 13; c++) begin
            check($sformatf("ab_c%0d", c), 32'(ab_tr[c]), 32'((c - 2) / 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
